// File: rtl/axi4_lite_rr_arbiter.sv
// Round-robin bus-ownership arbiter for the shared AXI4-Lite master port; holds one grant per transaction.
// Optional idle-owner revocation is compiled in with the ARB_TIMEOUT_EN macro.
module axi4_lite_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IW-1:0]          grant_id,
  output logic                   bus_busy,
  output logic                   timeout_pulse,
  input  logic                   AWVALID,
  input  logic                   AWREADY,
  input  logic                   ARVALID,
  input  logic                   ARREADY,
  input  logic                   BVALID,
  input  logic                   BREADY,
  input  logic                   RVALID,
  input  logic                   RREADY
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OWN  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_WRRD = 3'd4
  } state_t;

  // First requester strictly after 'last', wrapping; returns 'last' when nobody requests.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                            input logic [IW-1:0] last);
    logic          found;
    logic [IW-1:0] win;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    found = 1'b0;
    win   = last;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      sum = {1'b0, last} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_MASTERS)) begin
        sum = sum - (IW+1)'(NUM_MASTERS);
      end else begin
        sum = sum;
      end
      idx = sum[IW-1:0];
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  state_t                 state_r, state_nxt_s;
  logic [NUM_MASTERS-1:0] grant_r, grant_nxt_s;
  logic [IW-1:0]          grant_id_r, grant_id_nxt_s;
  logic [IW-1:0]          last_r, last_nxt_s;
  logic                   b_done_r, b_done_nxt_s;
  logic                   r_done_r, r_done_nxt_s;
  logic                   bus_busy_r;
  logic                   timeout_s;
  logic [IW-1:0]          pick_s;
  logic                   aw_hs_s, ar_hs_s, b_hs_s, r_hs_s;
  logic                   b_seen_s, r_seen_s;

  assign aw_hs_s  = AWVALID & AWREADY;
  assign ar_hs_s  = ARVALID & ARREADY;
  assign b_hs_s   = BVALID & BREADY;
  assign r_hs_s   = RVALID & RREADY;
  assign b_seen_s = b_done_r | b_hs_s;
  assign r_seen_s = r_done_r | r_hs_s;
  assign pick_s   = rr_pick(req, last_r);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          timeout_pulse_r;
`endif

  // Next-state, grant and completion-tracking logic.
  always_comb begin
    state_nxt_s    = state_r;
    grant_nxt_s    = grant_r;
    grant_id_nxt_s = grant_id_r;
    last_nxt_s     = last_r;
    b_done_nxt_s   = b_done_r;
    r_done_nxt_s   = r_done_r;
    timeout_s      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_nxt_s      = cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_nxt_s    = ST_OWN;
          grant_nxt_s    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_s;
          grant_id_nxt_s = pick_s;
          last_nxt_s     = pick_s;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt_s      = '0;
`endif
        end else begin
          grant_nxt_s = '0;
        end
      end
      ST_OWN: begin
        if (aw_hs_s && ar_hs_s) begin
          state_nxt_s  = ST_WRRD;
          b_done_nxt_s = 1'b0;
          r_done_nxt_s = 1'b0;
        end else if (aw_hs_s) begin
          state_nxt_s = ST_WR;
        end else if (ar_hs_s) begin
          state_nxt_s = ST_RD;
        end else if (!req[grant_id_r]) begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = '0;
        end else begin
`ifdef ARB_TIMEOUT_EN
          // Revoke on the edge that closes the TIMEOUT_CYCLES-th idle OWN cycle; last keeps the revoked master.
          if (cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
            state_nxt_s = ST_IDLE;
            grant_nxt_s = '0;
            timeout_s   = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
`else
          state_nxt_s = ST_OWN;
`endif
        end
      end
      ST_WR: begin
        if (b_hs_s) begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = '0;
        end else begin
          state_nxt_s = ST_WR;
        end
      end
      ST_RD: begin
        if (r_hs_s) begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = '0;
        end else begin
          state_nxt_s = ST_RD;
        end
      end
      ST_WRRD: begin
        if (b_seen_s && r_seen_s) begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = '0;
        end else begin
          b_done_nxt_s = b_seen_s;
          r_done_nxt_s = r_seen_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r    <= ST_IDLE;
      grant_r    <= '0;
      grant_id_r <= '0;
      last_r     <= IW'(NUM_MASTERS - 1);
      b_done_r   <= 1'b0;
      r_done_r   <= 1'b0;
      bus_busy_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      grant_r    <= grant_nxt_s;
      grant_id_r <= grant_id_nxt_s;
      last_r     <= last_nxt_s;
      b_done_r   <= b_done_nxt_s;
      r_done_r   <= r_done_nxt_s;
      bus_busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Idle-owner counter and the one-cycle revocation pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_r           <= '0;
      timeout_pulse_r <= 1'b0;
    end else begin
      cnt_r           <= cnt_nxt_s;
      timeout_pulse_r <= timeout_s;
    end
  end
  assign timeout_pulse = timeout_pulse_r;
`else
  assign timeout_pulse = 1'b0;
`endif

  assign grant    = grant_r;
  assign grant_id = grant_id_r;
  assign bus_busy = bus_busy_r;

endmodule

// File: doc/axi4_lite_rr_arbiter.md
# axi4_lite_rr_arbiter

Round-robin bus-ownership arbiter for the shared AXI4-Lite interconnect (Addr_Width = Data_Width = 32 from the `axi4_lite_Defs` package). It grants exactly one of NUM_MASTERS requesters ownership of the muxed AXI4-Lite master port. It holds that grant for exactly one complete transaction by snooping the channel handshakes on the muxed bus, then re-arbitrates. The external master mux uses `grant_id` as its select; this block carries no address or data.

## Interface
Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- TIMEOUT_CYCLES, 16, cycles a granted master may idle before revocation (used only with ARB_TIMEOUT_EN)

Ports:
- ACLK  in  1  bus clock, all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- req  in  NUM_MASTERS  per-master ownership request, level-held until transaction done
- grant  out  NUM_MASTERS  one-hot grant, registered
- grant_id  out  $clog2(NUM_MASTERS)  index of granted master, valid when bus_busy
- bus_busy  out  1  high whenever state != IDLE
- timeout_pulse  out  1  one-cycle pulse on grant revocation by timeout
- AWVALID, AWREADY, ARVALID, ARREADY  in  1 each  snooped address handshakes on muxed bus
- BVALID, BREADY, RVALID, RREADY  in  1 each  snooped response handshakes on muxed bus

## Operation
- Reset values: grant=0, grant_id=0, bus_busy=0, timeout_pulse=0, state=IDLE, last pointer=NUM_MASTERS-1, so master 0 has first priority.
- States: IDLE, OWN, WR, RD, WRRD.
- IDLE: if req != 0, select the first set bit searching upward from last+1 with wrap, go to OWN, load grant/grant_id, and update last to the winner. If req == 0, stay in IDLE.
- OWN: the master holds the bus and no address phase has been accepted yet.
  - AW handshake only → WR.
  - AR handshake only → RD.
  - AW and AR handshakes in the same cycle → WRRD.
  - req[grant_id] deasserted with no handshake → IDLE, and grant clears.
- WR: stay until BVALID&&BREADY, then IDLE.
- RD: stay until RVALID&&RREADY, then IDLE.
- WRRD: track B done and R done separately; go to IDLE once both are seen. Both may arrive in the same cycle.
- req changes while in WR/RD/WRRD are ignored. Once the address handshake occurs, the transaction always completes.
- Further AW/AR handshakes seen in WR/RD/WRRD are protocol errors. They are ignored and do not extend the grant.
- Transitions into IDLE clear grant on the same edge. A master is never granted twice in a row while another master is requesting.

## Timing
- Grant latency: req sampled high at edge N in IDLE → grant valid after edge N. grant is first visible in the cycle following the request.
- Completion: the B/R handshake is sampled at edge M → grant=0 after edge M.
  - IDLE occupies the cycle after edge M.
  - The next grant appears after edge M+1, giving a minimum of one dead cycle between owners.
- Back-to-back single requester: grant follows a 1-high-per-transaction, 1-low pattern.
- Asynchronous reset mid-transaction: all outputs go to reset values immediately, with no wait for the edge. An in-flight transaction is abandoned; the bench must also reset the slave.
- grant_id width: max(1, $clog2(NUM_MASTERS)).

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter clears on entry to OWN and increments each OWN cycle without an AW or AR handshake.
  - When the count reaches TIMEOUT_CYCLES, the block goes to IDLE on that edge and clears grant.
  - timeout_pulse is high for exactly the following cycle, and last stays at the revoked master.
  - Timeout never applies in WR/RD/WRRD.
- ARB_TIMEOUT_EN undefined: OWN waits indefinitely. The counter is not synthesized, and timeout_pulse is tied 0.

## Test plan
- Reset, then req=4'b0001 and a write (AW then B 3 cycles later):
  - grant=0001 one cycle after req.
  - bus_busy stays high through the B handshake.
  - grant=0 the cycle after B.
- req=4'b1111 held, each master performs one read: grant order 0001,0010,0100,1000,0001 with exactly one idle cycle between grants.
- Master 2 granted, AW and AR handshakes in the same cycle, R returns 2 cycles before B: grant held until B handshake, then released.
- Master 1 granted, drops req before any handshake: state returns to IDLE and grant=0 next edge, with no timeout_pulse.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, master 0 granted and never issues AW/AR:
  - grant drops after 16 OWN cycles and timeout_pulse is high for 1 cycle.
  - With req=4'b0011, the next grant goes to master 1.
- ARESETN pulsed low mid-WR: grant/bus_busy go to 0 asynchronously, and after release master 0 has priority again.
